ycrcb422_pixel_sequencer: RTL and testbench
===========================================

Name: ycrcb422_pixel_sequencer

Overview:
- Sequences a 4:2:2 byte stream (Cb, Y0, Cr, Y1 order) from the camera front end through the team's existing combinational ycrcb2rgb converter.
- Emits one 24-bit RGB pixel per handshake, tagged with frame coordinates, into the frame-buffer writer.
- Owns chroma pairing, the offset-binary to signed conversion, output buffering with backpressure, and frame resynchronisation.

Parameters:
- H_ACTIVE, 640: pixels per line; sets the out_x wrap point.
- V_ACTIVE, 480: lines per frame; sets the out_y wrap point.
- FIFO_DEPTH, 2: output buffer entries. Must be at least 2; a power of 2 is not required.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_byte  in  8  stream byte.
- in_sof  in  1  qualifies in_byte as the Cb byte of pixel (0,0).
- in_valid  in  1  in_byte and in_sof are valid.
- in_ready  out  1  block accepts the byte this cycle.
- out_rgb  out  24  {r,g,b}, 8 bits each.
- out_x  out  10  pixel column.
- out_y  out  9  pixel line.
- out_sof  out  1  high on the pixel at (0,0).
- out_valid  out  1  output fields valid.
- out_ready  in  1  sink accepts this cycle.
- sync_err  out  1  sticky; in_sof was seen mid-group.

Behaviour:
- Reset values (asynchronous, while reset_n=0): state=S_CB, FIFO empty, out_valid=0, out_rgb=0, out_x=0, out_y=0, out_sof=0, sync_err=0, coordinate counters=0. Reset mid-group discards the partial group and all buffered pixels.
- Byte transfer: a byte is accepted when in_valid && in_ready.
- FSM: S_CB -> S_Y0 -> S_CR -> S_Y1 -> S_CB, advancing one state per accepted byte.
  - S_CB: latch cb = in_byte - 128, as signed 10-bit.
  - S_Y0: latch y0 = {2'b0, in_byte}.
  - S_CR: form cr = in_byte - 128, drive the converter with (y0, cr, cb), push pixel 0. Latch cr.
  - S_Y1: drive the converter with ({2'b0,in_byte}, cr_latched, cb), push pixel 1.
- in_ready:
  - Always 1 in S_CB and S_Y0.
  - In S_CR and S_Y1: in_ready = !full, using the registered count only. There is no combinational path from out_ready to in_ready.
- Pixel push: writes {rgb, x, y, sof} into the FIFO, then advances the coordinate counters.
  - x increments and wraps at H_ACTIVE-1 to 0.
  - On an x wrap, y increments and wraps at V_ACTIVE-1 to 0.
  - sof=1 when the pushed pixel is at x=0 and y=0.
- Converter output widths: r, g and b are taken as the converter's 8-bit results. No extra clamping; overflow wraps mod 256, matching converter behaviour.
- Output:
  - out_* reflect the FIFO head, registered.
  - out_valid=1 whenever the FIFO is non-empty.
  - Pop on out_valid && out_ready.
  - Fields must hold stable while out_valid && !out_ready.
- Latency: a push in cycle N appears with out_valid=1 in cycle N+1 when the FIFO was empty.
- Simultaneous push and pop: allowed in the same cycle. When full, the push is blocked by in_ready=0, so no overflow is possible. Count is unchanged on push+pop.
- Resync, when in_sof arrives with an accepted byte:
  - Counters reset so the next pushed pixel is at (0,0).
  - The byte is treated as Cb and the state goes to S_Y0.
  - If the state was not S_CB: set sync_err and drop the partial group. Pixels already pushed remain in the FIFO.
- Byte accepted in S_CB without in_sof: normal continuation.
- sync_err clears only on reset.

Decomposition:
- Shared package ycrcb_pkg:
  - state enum (S_CB, S_Y0, S_CR, S_Y1);
  - CHROMA_OFFSET=128;
  - pixel record width (24+10+9+1).
- Instantiate the existing ycrcb2rgb once, muxing its y/cr inputs by state.
- One sub-module: pixel_fifo, a synchronous FIFO parameterised on FIFO_DEPTH and width, with a registered head and full/empty flags.

Test Plan:
- Neutral chroma: sof+Cb=128, Y0=100, Cr=128, Y1=200 with out_ready=1 -> pixels (100,100,100) at (0,0) with out_sof=1, then (200,200,200) at (1,0). Pixel 0 out_valid exactly one cycle after Cr is accepted.
- Colour math: Cb=192, Y0=100, Cr=128, Y1=100 -> both pixels r=173, g=63, b=100.
- Backpressure, FIFO_DEPTH=2, out_ready=0:
  - Send 8 bytes -> in_ready=0 in S_CR of the second group after 2 pixels are buffered; out_rgb stable.
  - Raise out_ready -> pixels drain in order, none lost or duplicated.
- Resync: in_sof on the 3rd byte of a group -> sync_err=1; the next pixel is at (0,0) with out_sof=1, using that byte as Cb.
- Wrap, H_ACTIVE=4, V_ACTIVE=2: 9 pixels -> coordinates (0,0)..(3,0),(0,1)..(3,1),(0,0), with out_sof=1 on the 9th.
- Reset asserted mid-group with 1 pixel buffered -> out_valid=0 immediately, state S_CB. After release, a fresh group yields correct pixels.

Source files
------------

// File: rtl/ycrcb422_pixel_sequencer_pkg.sv
// Shared types and constants for the 4:2:2 pixel sequencer slice.
// Holds the byte-phase enum, the chroma offset and the buffered pixel record.
package ycrcb_pkg;

   typedef enum logic [1:0] {
      S_CB,
      S_Y0,
      S_CR,
      S_Y1
   } state_t;

   localparam int CHROMA_OFFSET = 128;
   localparam int PIX_W         = 24 + 10 + 9 + 1;

   typedef struct packed {
      logic [23:0] rgb;
      logic [9:0]  x;
      logic [8:0]  y;
      logic        sof;
   } pixel_t;

   // Offset-binary chroma byte to signed 10-bit
   function automatic logic signed [9:0] to_chroma(input logic [7:0] b);
      return signed'({2'b00, b}) - 10'(CHROMA_OFFSET);
   endfunction

endpackage

// File: rtl/ycrcb422_pixel_sequencer_if.sv
// Byte-stream input and tagged-pixel output handshakes of the sequencer.
interface ycrcb422_pixel_sequencer_if;
   logic [7:0]  in_byte;
   logic        in_sof;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] out_rgb;
   logic [9:0]  out_x;
   logic [8:0]  out_y;
   logic        out_sof;
   logic        out_valid;
   logic        out_ready;
   logic        sync_err;

   modport master (
      output in_byte, in_sof, in_valid, out_ready,
      input  in_ready, out_rgb, out_x, out_y, out_sof, out_valid, sync_err
   );

   modport slave (
      input  in_byte, in_sof, in_valid, out_ready,
      output in_ready, out_rgb, out_x, out_y, out_sof, out_valid, sync_err
   );
endinterface

// File: rtl/ycrcb2rgb.sv
// Combinational Y/Cr/Cb to RGB converter, 8.8 fixed-point coefficients.
// Results wrap mod 256; no clamping is applied.
module ycrcb2rgb (
   input  logic [9:0]        y,
   input  logic signed [9:0] cr,
   input  logic signed [9:0] cb,
   output logic [7:0]        r,
   output logic [7:0]        g,
   output logic [7:0]        b
);

   localparam logic signed [19:0] K_R  = 20'sd292;
   localparam logic signed [19:0] K_GB = 20'sd149;
   localparam logic signed [19:0] K_GR = 20'sd101;
   localparam logic signed [19:0] K_B  = 20'sd520;

   logic signed [19:0] ys, cbx, crx;

   assign ys  = {10'b0, y};
   assign cbx = {{10{cb[9]}}, cb};
   assign crx = {{10{cr[9]}}, cr};

   // Camera-path operand naming: the cb operand carries the red-difference term
   assign r = 8'(ys + ((K_R * cbx) >>> 8));
   assign g = 8'(ys - ((K_GB * cbx) >>> 8) - ((K_GR * crx) >>> 8));
   assign b = 8'(ys + ((K_B * crx) >>> 8));

endmodule

// File: rtl/ycrcb422_pixel_sequencer_pixel_fifo.sv
// Shift-register FIFO whose entry 0 is the registered head.
// Push and pop may coincide; a push while full is ignored.
module pixel_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 44
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int          CW = $clog2(DEPTH + 1);
   localparam int unsigned D  = DEPTH;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] nxt [DEPTH];
   logic [CW-1:0]    count, wr_idx;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && !full;
   assign wr_idx  = do_pop ? count - CW'(1) : count;
   assign dout    = mem[0];

   always_comb begin
      nxt = mem;
      if (do_pop)
         for (int unsigned i = 0; i + 1 < D; i++) nxt[i] = mem[i+1];
      if (do_push)
         for (int unsigned i = 0; i < D; i++)
            if (CW'(i) == wr_idx) nxt[i] = din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         for (int unsigned i = 0; i < D; i++) mem[i] <= '0;
      end else begin
         mem <= nxt;
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (!do_push && do_pop)
            count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/ycrcb422_pixel_sequencer.sv
// Pairs Cb/Y0/Cr/Y1 bytes into two RGB pixels tagged with frame coordinates,
// buffering them behind a small FIFO and resynchronising on in_sof.
module ycrcb422_pixel_sequencer
   import ycrcb_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 2
) (
   input logic                      clk,
   input logic                      reset_n,
   ycrcb422_pixel_sequencer_if.slave bus
);

   localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
   localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

   state_t            state;
   logic signed [9:0] cb_q, cr_q, conv_cr;
   logic [7:0]        y0_q;
   logic [9:0]        conv_y, x_cnt;
   logic [8:0]        y_cnt;
   logic              sync_err_q;
   logic              accept, push, pop, full, empty;
   logic [7:0]        r, g, b;
   logic [PIX_W-1:0]  head_bits;
   pixel_t            push_pix, head;

   // Chroma-bearing bytes stall on the registered fill level only
   assign bus.in_ready = (state == S_CB || state == S_Y0) ? 1'b1 : !full;
   assign accept       = bus.in_valid && bus.in_ready;
   assign push         = accept && !bus.in_sof && (state == S_CR || state == S_Y1);
   assign pop          = bus.out_ready && !empty;

   always_comb begin
      conv_y  = (state == S_Y1) ? {2'b00, bus.in_byte} : {2'b00, y0_q};
      conv_cr = (state == S_CR) ? to_chroma(bus.in_byte) : cr_q;
   end

   ycrcb2rgb u_conv (
      .y  (conv_y),
      .cr (conv_cr),
      .cb (cb_q),
      .r  (r),
      .g  (g),
      .b  (b)
   );

   always_comb begin
      push_pix.rgb = {r, g, b};
      push_pix.x   = x_cnt;
      push_pix.y   = y_cnt;
      push_pix.sof = (x_cnt == '0) && (y_cnt == '0);
   end

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (push_pix),
      .pop     (pop),
      .dout    (head_bits),
      .full    (full),
      .empty   (empty)
   );

   assign head          = head_bits;
   assign bus.out_rgb   = head.rgb;
   assign bus.out_x     = head.x;
   assign bus.out_y     = head.y;
   assign bus.out_sof   = head.sof;
   assign bus.out_valid = !empty;
   assign bus.sync_err  = sync_err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_CB;
         cb_q       <= '0;
         cr_q       <= '0;
         y0_q       <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         sync_err_q <= 1'b0;
      end else if (accept) begin
         if (bus.in_sof) begin
            // Any byte flagged sof restarts a group as Cb at pixel (0,0)
            cb_q  <= to_chroma(bus.in_byte);
            state <= S_Y0;
            x_cnt <= '0;
            y_cnt <= '0;
            if (state != S_CB) sync_err_q <= 1'b1;
         end else begin
            unique case (state)
               S_CB: begin
                  cb_q  <= to_chroma(bus.in_byte);
                  state <= S_Y0;
               end
               S_Y0: begin
                  y0_q  <= bus.in_byte;
                  state <= S_CR;
               end
               S_CR: begin
                  cr_q  <= conv_cr;
                  state <= S_Y1;
               end
               S_Y1: state <= S_CB;
            endcase
            if (push) begin
               if (x_cnt == X_LAST) begin
                  x_cnt <= '0;
                  y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 9'd1;
               end else begin
                  x_cnt <= x_cnt + 10'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ycrcb422_pixel_sequencer.sv
// Directed and randomized bench for ycrcb422_pixel_sequencer against a
// byte-group reference model with an expected-pixel queue.
module tb_ycrcb422_pixel_sequencer;

   localparam int H     = 4;
   localparam int V     = 2;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ycrcb422_pixel_sequencer_if bus ();

   ycrcb422_pixel_sequencer #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int          total = 0;
   int          bad   = 0;
   logic [43:0] expq[$];
   logic [43:0] seen[$];
   int          grp[$];
   int          cx, cy;
   bit          err_m;
   bit          hold_pend;
   logic [43:0] held;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] conv(input int y, input int cb, input int cr);
      int u, v, r, g, b;
      u = cb - 128;
      v = cr - 128;
      r = y + ((292 * u) >>> 8);
      g = y - ((149 * u) >>> 8) - ((101 * v) >>> 8);
      b = y + ((520 * v) >>> 8);
      return {8'(r & 255), 8'(g & 255), 8'(b & 255)};
   endfunction

   task automatic emit(input int y, input int cb, input int cr);
      expq.push_back({conv(y, cb, cr), 10'(cx), 9'(cy), (cx == 0 && cy == 0)});
      cx = (cx + 1) % H;
      if (cx == 0) cy = (cy + 1) % V;
   endtask

   task automatic model_accept(input int b, input bit sof);
      if (sof) begin
         if (grp.size() != 0) err_m = 1'b1;
         grp.delete();
         cx = 0;
         cy = 0;
      end
      grp.push_back(b);
      if (grp.size() == 3) emit(grp[1], grp[0], grp[2]);
      if (grp.size() == 4) begin
         emit(grp[3], grp[0], grp[2]);
         grp.delete();
      end
   endtask

   task automatic model_reset();
      expq.delete();
      grp.delete();
      cx = 0;
      cy = 0;
      err_m = 1'b0;
      hold_pend = 1'b0;
   endtask

   // One clock: observe at negedge, update the model, return #1 after posedge
   task automatic cycle(output bit acc);
      logic [43:0] cur;
      @(negedge clk);
      cur = {bus.out_rgb, bus.out_x, bus.out_y, bus.out_sof};
      check_eq("out_valid", bus.out_valid, expq.size() != 0);
      check_eq("in_ready", bus.in_ready,
               !(((grp.size() == 2) || (grp.size() == 3)) && expq.size() == DEPTH));
      check_eq("sync_err", bus.sync_err, err_m);
      if (hold_pend && bus.out_valid) check_eq("hold", cur, held);
      hold_pend = bus.out_valid && !bus.out_ready;
      held = cur;
      if (bus.out_valid && bus.out_ready && expq.size() != 0) begin
         check_eq("pixel", cur, expq.pop_front());
         seen.push_back(cur);
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) model_accept(int'(bus.in_byte), bus.in_sof);
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input int b, input bit sof);
      bit acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'(b);
      bus.in_sof   = sof;
      for (int i = 0; i < 100 && !acc; i++) cycle(acc);
      check_eq("accept", acc, 1);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic send_group(input int cb, input int y0, input int cr, input int y1, input bit sof);
      send_byte(cb, sof);
      send_byte(y0, 1'b0);
      send_byte(cr, 1'b0);
      send_byte(y1, 1'b0);
   endtask

   task automatic drain();
      bit a;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 200 && expq.size() != 0; i++) cycle(a);
      cycle(a);
      check_eq("drained", expq.size(), 0);
   endtask

   task automatic check_pix(input string tag, input int idx, input logic [43:0] exp);
      logic [43:0] got = '0;
      if (idx < seen.size()) got = seen[idx];
      check_eq(tag, got, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      bit a;
      logic [43:0] px;
      bus.in_valid  = 1'b0;
      bus.in_byte   = '0;
      bus.in_sof    = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();

      #1;
      check_eq("rst_valid", bus.out_valid, 0);
      check_eq("rst_rgb", bus.out_rgb, 0);
      check_eq("rst_xy", {bus.out_x, bus.out_y, bus.out_sof}, 0);
      check_eq("rst_err", bus.sync_err, 0);
      check_eq("rst_ready", bus.in_ready, 1);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Neutral chroma, with first-pixel latency
      bus.out_ready = 1'b1;
      seen.delete();
      send_byte(128, 1'b1);
      send_byte(100, 1'b0);
      send_byte(128, 1'b0);
      check_eq("lat_valid", bus.out_valid, 1);
      check_eq("lat_pix", {bus.out_rgb, bus.out_x, bus.out_y, bus.out_sof},
               {24'h646464, 10'd0, 9'd0, 1'b1});
      send_byte(200, 1'b0);
      drain();
      check_pix("neutral0", 0, {24'h646464, 10'd0, 9'd0, 1'b1});
      check_pix("neutral1", 1, {24'hC8C8C8, 10'd1, 9'd0, 1'b0});

      // Colour math
      seen.delete();
      send_group(192, 100, 128, 100, 1'b0);
      drain();
      check_pix("colour0", 0, {24'hAD3F64, 10'd2, 9'd0, 1'b0});
      check_pix("colour1", 1, {24'hAD3F64, 10'd3, 9'd0, 1'b0});

      // Backpressure with a two-entry buffer
      seen.delete();
      bus.out_ready = 1'b0;
      send_group(120, 50, 130, 60, 1'b0);
      send_byte(100, 1'b0);
      send_byte(70, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'd140;
      for (int i = 0; i < 4; i++) begin
         cycle(a);
         check_eq("bp_stall", a, 0);
      end
      check_eq("bp_ready", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      send_byte(140, 1'b0);
      send_byte(80, 1'b0);
      drain();
      check_eq("bp_count", seen.size(), 4);
      check_pix("bp0", 0, {conv(50, 120, 130), 10'd0, 9'd1, 1'b0});
      check_pix("bp1", 1, {conv(60, 120, 130), 10'd1, 9'd1, 1'b0});
      check_pix("bp2", 2, {conv(70, 100, 140), 10'd2, 9'd1, 1'b0});
      check_pix("bp3", 3, {conv(80, 100, 140), 10'd3, 9'd1, 1'b0});

      // Resync on the third byte of a group
      send_group(90, 40, 160, 45, 1'b0);
      drain();
      seen.delete();
      send_byte(10, 1'b0);
      send_byte(20, 1'b0);
      send_byte(128, 1'b1);
      send_byte(50, 1'b0);
      send_byte(128, 1'b0);
      send_byte(60, 1'b0);
      drain();
      check_eq("resync_err", bus.sync_err, 1);
      check_pix("resync0", 0, {24'h323232, 10'd0, 9'd0, 1'b1});
      check_pix("resync1", 1, {24'h3C3C3C, 10'd1, 9'd0, 1'b0});

      // Coordinate wrap over one full frame plus one pixel
      seen.delete();
      for (int k = 0; k < 5; k++)
         send_group($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255), k == 0);
      drain();
      check_eq("wrap_count", seen.size(), 10);
      for (int i = 0; i < 9; i++) begin
         px = (i < seen.size()) ? seen[i] : '1;
         check_eq("wrap_x", px[19:10], i % H);
         check_eq("wrap_y", px[9:1], (i / H) % V);
         check_eq("wrap_sof", px[0], (i % (H * V)) == 0);
      end

      // Reset with one pixel buffered and a group half consumed
      bus.out_ready = 1'b0;
      send_byte(128, 1'b0);
      send_byte(30, 1'b0);
      send_byte(128, 1'b0);
      check_eq("pre_rst_valid", bus.out_valid, 1);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", bus.out_valid, 0);
      check_eq("mid_rst_err", bus.sync_err, 0);
      check_eq("mid_rst_ready", bus.in_ready, 1);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      bus.out_ready = 1'b1;
      seen.delete();
      send_group(128, 90, 128, 91, 1'b0);
      drain();
      check_pix("post_rst0", 0, {24'h5A5A5A, 10'd0, 9'd0, 1'b1});
      check_pix("post_rst1", 1, {24'h5B5B5B, 10'd1, 9'd0, 1'b0});

      // Randomized traffic, occasional sof, random backpressure
      for (int i = 0; i < 3000; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_byte   = 8'($urandom);
         bus.in_sof    = ($urandom_range(0, 15) == 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         cycle(a);
      end
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
